// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first; one operation every WIDTH+2 cycles.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the operation into A-B.
`default_nettype none
module serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MSB_IN = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q;
  logic             c_msb_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             sum_d;
  logic             carry_d;
  logic [WIDTH-1:0] b_load_d;
  logic             c_load_d;

  assign sum_d   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign carry_d = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1, so cout=1 means no borrow.
  assign b_load_d = sub ? ~op_b : op_b;
  assign c_load_d = sub ? 1'b1 : cin;
`else
  assign b_load_d = op_b;
  assign c_load_d = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      c_msb_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= op_a;
            b_sh_q  <= b_load_d;
            c_q     <= c_load_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          result_q <= {sum_d, result_q[WIDTH-1:1]};
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          c_q      <= carry_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          // Carry into the MSB position is needed later for signed overflow.
          if (cnt_q == CNT_MSB_IN) begin
            c_msb_q <= carry_d;
          end
          if (cnt_q == CNT_LAST) begin
            cout_q  <= carry_d;
            ovf_q   <= c_msb_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
endmodule
`default_nettype wire
